uart_ascii_accumulator: RTL and testbench

//  Parametrised ASCII-command accumulator sitting between the UART RX byte path and the UART TX byte path.

---
 rtl/uart_ascii_accumulator_if.sv | 20 ++
 rtl/uart_ascii_accumulator.sv | 188 ++++++++++++++++++
 tb/tb_uart_ascii_accumulator.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_ascii_accumulator_if.sv
// Byte-stream bundle between the UART RX/TX paths and the ASCII accumulator.
// rx_valid is a one-cycle strobe with no back-pressure; a TX byte transfers on any
// rising edge where tx_valid && tx_ready, and tx_valid/tx_data hold until then.
interface uart_ascii_accumulator_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output rx_data, rx_valid, tx_ready,
      input  tx_data, tx_valid
   );

   modport slave (
      input  rx_data, rx_valid, tx_ready,
      output tx_data, tx_valid
   );
endinterface

// File: rtl/uart_ascii_accumulator.sv
// ASCII hex-digit accumulator: decodes RX bytes into add/sub/reset commands and
// reports each new accumulator value over TX as uppercase hex, optionally CR-terminated.
module uart_ascii_accumulator #(
   parameter int ACC_W        = 8,
   parameter int SATURATE     = 0,
   parameter int ECHO_CR      = 1,
   parameter int ACCEPT_LOWER = 1
) (
   input  logic                      CLOCK_50,
   input  logic                      Reset_n,
   input  logic                      clr,
   uart_ascii_accumulator_if.slave   bus,
   output logic [ACC_W-1:0]          acc,
   output logic [3:0]                last_digit,
   output logic                      digit_stb,
   output logic                      ovf,
   output logic                      busy,
   output logic [1:0]                dbg_state
);

   localparam int NIB   = ACC_W / 4;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_SEND = 2'd2, S_CR = 2'd3} state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               ovf_q, ovf_d;
   logic               op_sub_q, op_sub_d;
   logic [3:0]         last_digit_q, last_digit_d;
   logic               digit_stb_q, digit_stb_d;
   logic               pending_q, pending_d;
   logic [ACC_W-1:0]   snap_q, snap_d;
   logic [IDX_W-1:0]   idx_q, idx_d;

   logic               is_digit, is_plus, is_minus, is_reset, req_now, hs;
   logic [3:0]         digit_val, tx_nib;
   logic [ACC_W:0]     sum_ext;

   // Command decode; clr masks the byte entirely.
   always_comb begin
      is_digit  = 1'b0;
      is_plus   = 1'b0;
      is_minus  = 1'b0;
      is_reset  = 1'b0;
      digit_val = 4'd0;
      if (bus.rx_valid && !clr) begin
         if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
            is_digit  = 1'b1;
            digit_val = bus.rx_data[3:0];
         end else if (bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) begin
            is_digit  = 1'b1;
            digit_val = bus.rx_data[3:0] + 4'd9;
         end else if (ACCEPT_LOWER != 0 && bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66) begin
            is_digit  = 1'b1;
            digit_val = bus.rx_data[3:0] + 4'd9;
         end else if (bus.rx_data == 8'h2B) begin
            is_plus = 1'b1;
         end else if (bus.rx_data == 8'h2D) begin
            is_minus = 1'b1;
         end else if (bus.rx_data == 8'h52 || bus.rx_data == 8'h72) begin
            is_reset = 1'b1;
         end
      end
   end

   assign req_now = is_digit || is_reset;
   assign sum_ext = op_sub_q ? ({1'b0, acc_q} - {{(ACC_W-3){1'b0}}, digit_val})
                             : ({1'b0, acc_q} + {{(ACC_W-3){1'b0}}, digit_val});

   // sum_ext[ACC_W] is the carry on add and the borrow on sub.
   always_comb begin
      acc_d        = acc_q;
      ovf_d        = ovf_q;
      op_sub_d     = op_sub_q;
      last_digit_d = last_digit_q;
      digit_stb_d  = 1'b0;
      if (clr) begin
         acc_d    = '0;
         ovf_d    = 1'b0;
         op_sub_d = 1'b0;
      end else if (is_digit) begin
         digit_stb_d  = 1'b1;
         last_digit_d = digit_val;
         acc_d        = sum_ext[ACC_W-1:0];
         if (sum_ext[ACC_W]) begin
            ovf_d = 1'b1;
            if (SATURATE != 0) acc_d = op_sub_q ? '0 : '1;
         end
      end else if (is_reset) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (is_plus) begin
         op_sub_d = 1'b0;
      end else if (is_minus) begin
         op_sub_d = 1'b1;
      end
   end

   // A request arriving in LOAD or later postdates the snapshot, so it must stay pending.
   always_comb begin
      if (clr)                              pending_d = 1'b0;
      else if (req_now && state_q != S_IDLE) pending_d = 1'b1;
      else if (state_q == S_LOAD)           pending_d = 1'b0;
      else                                  pending_d = pending_q;
   end

   assign hs = (state_q == S_SEND || state_q == S_CR) && bus.tx_ready;

   always_comb begin
      snap_d = snap_q;
      idx_d  = idx_q;
      if (state_q == S_LOAD) begin
         snap_d = acc_q;
         idx_d  = IDX_W'(NIB - 1);
      end else if (state_q == S_SEND && hs) begin
         snap_d = snap_q << 4;
         if (idx_q != '0) idx_d = idx_q - 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
      if (!Reset_n) begin
         acc_q        <= '0;
         ovf_q        <= 1'b0;
         op_sub_q     <= 1'b0;
         last_digit_q <= 4'd0;
         digit_stb_q  <= 1'b0;
         pending_q    <= 1'b0;
         snap_q       <= '0;
         idx_q        <= '0;
      end else begin
         acc_q        <= acc_d;
         ovf_q        <= ovf_d;
         op_sub_q     <= op_sub_d;
         last_digit_q <= last_digit_d;
         digit_stb_q  <= digit_stb_d;
         pending_q    <= pending_d;
         snap_q       <= snap_d;
         idx_q        <= idx_d;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
      if (!Reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (req_now || (pending_q && !clr)) state_d = S_LOAD;
         S_LOAD: state_d = S_SEND;
         S_SEND: if (hs && idx_q == '0) state_d = (ECHO_CR != 0) ? S_CR : S_IDLE;
         S_CR:   if (hs) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign tx_nib = snap_q[ACC_W-1 -: 4];

   always_comb begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      case (state_q)
         S_SEND: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = (tx_nib < 4'd10) ? {4'h3, tx_nib} : (8'h37 + {4'h0, tx_nib});
         end
         S_CR: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = 8'h0D;
         end
         default: begin
            bus.tx_valid = 1'b0;
            bus.tx_data  = 8'h00;
         end
      endcase
   end

   assign acc        = acc_q;
   assign ovf        = ovf_q;
   assign last_digit = last_digit_q;
   assign digit_stb  = digit_stb_q;
   assign busy       = (state_q != S_IDLE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_ascii_accumulator.sv
// Drives three accumulator variants with the same byte stream and checks them
// against an integer-arithmetic model and an expected TX byte queue per variant.
module tb_uart_ascii_accumulator;

   // ---------------- clock / reset ----------------
   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       clr      = 1'b0;
   logic [7:0] rx_data  = 8'h00;
   logic       rx_valid = 1'b0;
   logic       tx_ready = 1'b0;
   bit         rnd_ready = 1'b0;

   always #10 clk = ~clk;

   // Variant 0: 8-bit wrap, CR, lowercase. Variant 1: 8-bit saturate, CR, no lowercase.
   // Variant 2: 16-bit wrap, no CR, lowercase.
   localparam int PW   [3] = '{8, 8, 16};
   localparam int PSAT [3] = '{0, 1, 0};
   localparam int PCR  [3] = '{1, 1, 0};
   localparam int PLOW [3] = '{1, 0, 1};

   uart_ascii_accumulator_if if0 ();
   uart_ascii_accumulator_if if1 ();
   uart_ascii_accumulator_if if2 ();

   assign if0.rx_data = rx_data;  assign if0.rx_valid = rx_valid;  assign if0.tx_ready = tx_ready;
   assign if1.rx_data = rx_data;  assign if1.rx_valid = rx_valid;  assign if1.tx_ready = tx_ready;
   assign if2.rx_data = rx_data;  assign if2.rx_valid = rx_valid;  assign if2.tx_ready = tx_ready;

   logic [7:0]  acc0, acc1;
   logic [15:0] acc2;
   logic [3:0]  ld     [3];
   logic        stb    [3];
   logic        ovf_o  [3];
   logic        busy_o [3];
   logic [1:0]  st     [3];
   logic [31:0] acc_a  [3];
   logic [7:0]  txd    [3];
   logic        txv    [3];

   assign acc_a[0] = {24'd0, acc0};
   assign acc_a[1] = {24'd0, acc1};
   assign acc_a[2] = {16'd0, acc2};
   assign txd[0] = if0.tx_data;  assign txv[0] = if0.tx_valid;
   assign txd[1] = if1.tx_data;  assign txv[1] = if1.tx_valid;
   assign txd[2] = if2.tx_data;  assign txv[2] = if2.tx_valid;

   uart_ascii_accumulator #(.ACC_W(8), .SATURATE(0), .ECHO_CR(1), .ACCEPT_LOWER(1)) dut0 (
      .CLOCK_50(clk), .Reset_n(rst_n), .clr(clr), .bus(if0), .acc(acc0), .last_digit(ld[0]),
      .digit_stb(stb[0]), .ovf(ovf_o[0]), .busy(busy_o[0]), .dbg_state(st[0]));
   uart_ascii_accumulator #(.ACC_W(8), .SATURATE(1), .ECHO_CR(1), .ACCEPT_LOWER(0)) dut1 (
      .CLOCK_50(clk), .Reset_n(rst_n), .clr(clr), .bus(if1), .acc(acc1), .last_digit(ld[1]),
      .digit_stb(stb[1]), .ovf(ovf_o[1]), .busy(busy_o[1]), .dbg_state(st[1]));
   uart_ascii_accumulator #(.ACC_W(16), .SATURATE(0), .ECHO_CR(0), .ACCEPT_LOWER(1)) dut2 (
      .CLOCK_50(clk), .Reset_n(rst_n), .clr(clr), .bus(if2), .acc(acc2), .last_digit(ld[2]),
      .digit_stb(stb[2]), .ovf(ovf_o[2]), .busy(busy_o[2]), .dbg_state(st[2]));

   // ---------------- scoreboard / model ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int extra   = 0;

   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];
   logic [7:0] exp_q2[$];

   longint     acc_m  [3];
   bit         ovf_m  [3];
   bit         sub_m  [3];
   bit         stb_m  [3];
   logic [3:0] last_m [3];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void push_exp(input int k, input logic [7:0] b);
      case (k)
         0: exp_q0.push_back(b);
         1: exp_q1.push_back(b);
         default: exp_q2.push_back(b);
      endcase
   endfunction

   function automatic int exp_size(input int k);
      case (k)
         0: return exp_q0.size();
         1: return exp_q1.size();
         default: return exp_q2.size();
      endcase
   endfunction

   function automatic logic [7:0] pop_exp(input int k);
      case (k)
         0: return exp_q0.pop_front();
         1: return exp_q1.pop_front();
         default: return exp_q2.pop_front();
      endcase
   endfunction

   // Queue the hex text of the model's current value, truncated to maxc bytes.
   function automatic void push_report(input int k, input int maxc);
      int n = 0;
      for (int i = PW[k] / 4 - 1; i >= 0; i--) begin
         int nib = int'((acc_m[k] >> (4 * i)) & 64'd15);
         if (n < maxc) begin
            push_exp(k, (nib < 10) ? 8'(48 + nib) : 8'(55 + nib));
            n++;
         end
      end
      if (PCR[k] != 0 && n < maxc) push_exp(k, 8'h0D);
   endfunction

   function automatic void model_reset(input int k);
      acc_m[k] = 0; ovf_m[k] = 0; sub_m[k] = 0; stb_m[k] = 0; last_m[k] = 4'd0;
   endfunction

   // Applies one received byte; returns 1 when the byte asks for a report.
   function automatic bit model_byte(input int k, input logic [7:0] b, input bit do_clr);
      int     d   = -1;
      longint lim = longint'(1) << PW[k];
      longint r;
      stb_m[k] = 0;
      if (do_clr) begin
         acc_m[k] = 0; ovf_m[k] = 0; sub_m[k] = 0;
         return 0;
      end
      if (b >= 8'h30 && b <= 8'h39) d = int'(b) - 48;
      else if (b >= 8'h41 && b <= 8'h46) d = int'(b) - 55;
      else if (PLOW[k] != 0 && b >= 8'h61 && b <= 8'h66) d = int'(b) - 87;
      if (d >= 0) begin
         r = sub_m[k] ? acc_m[k] - d : acc_m[k] + d;
         if (r < 0) begin
            ovf_m[k] = 1;
            r = (PSAT[k] != 0) ? 0 : r + lim;
         end else if (r >= lim) begin
            ovf_m[k] = 1;
            r = (PSAT[k] != 0) ? lim - 1 : r - lim;
         end
         acc_m[k]  = r;
         last_m[k] = 4'(d);
         stb_m[k]  = 1;
         return 1;
      end
      if (b == 8'h2B) sub_m[k] = 0;
      if (b == 8'h2D) sub_m[k] = 1;
      if (b == 8'h52 || b == 8'h72) begin
         acc_m[k] = 0; ovf_m[k] = 0;
         return 1;
      end
      return 0;
   endfunction

   // TX monitor: bytes are taken on negedges where a handshake is about to happen.
   bit         held_v [3];
   logic [7:0] held_d [3];

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (txv[k] && held_v[k]) check($sformatf("tx_stable[%0d]", k), {24'd0, txd[k]}, {24'd0, held_d[k]});
         if (txv[k] && tx_ready) begin
            if (exp_size(k) == 0) extra++;
            else check($sformatf("tx_byte[%0d]", k), {24'd0, txd[k]}, {24'd0, pop_exp(k)});
         end
         held_v[k] = txv[k] && !tx_ready;
         held_d[k] = txd[k];
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
   end

   // ---------------- driver tasks ----------------
   task automatic check_regs();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("acc[%0d]", k), acc_a[k], 32'(acc_m[k]));
         check($sformatf("ovf[%0d]", k), {31'd0, ovf_o[k]}, {31'd0, ovf_m[k]});
         check($sformatf("digit_stb[%0d]", k), {31'd0, stb[k]}, {31'd0, stb_m[k]});
         check($sformatf("last_digit[%0d]", k), {28'd0, ld[k]}, {28'd0, last_m[k]});
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit do_clr, input bit chk_lat, input bit push_rep);
      bit req [3];
      @(posedge clk); #1;
      rx_data = b; rx_valid = 1'b1; clr = do_clr;
      for (int k = 0; k < 3; k++) req[k] = model_byte(k, b, do_clr);
      @(posedge clk); #1;
      rx_valid = 1'b0; clr = 1'b0;
      @(negedge clk);
      check_regs();
      if (push_rep) for (int k = 0; k < 3; k++) if (req[k]) push_report(k, 99);
      @(negedge clk);
      if (chk_lat)
         for (int k = 0; k < 3; k++)
            check($sformatf("tx_valid_lat[%0d]", k), {31'd0, txv[k]}, {31'd0, req[k]});
   endtask

   task automatic wait_idle(input int maxc);
      int c = 0;
      int quiet = 0;
      while (quiet < 3 && c < maxc) begin
         @(negedge clk);
         c++;
         if (busy_o[0] || busy_o[1] || busy_o[2]) quiet = 0;
         else quiet++;
      end
      if (quiet < 3) check("idle_timeout", {29'd0, busy_o[0], busy_o[1], busy_o[2]}, 32'd0);
   endtask

   task automatic send_idle(input logic [7:0] b);
      send_byte(b, 1'b0, 1'b1, 1'b1);
      wait_idle(300);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] b;
      for (int k = 0; k < 3; k++) model_reset(k);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_regs();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_busy[%0d]", k), {31'd0, busy_o[k]}, 32'd0);
         check($sformatf("rst_tx_valid[%0d]", k), {31'd0, txv[k]}, 32'd0);
      end
      rst_n = 1'b1;

      // Two digits with free-running TX
      tx_ready = 1'b1;
      send_idle("3");
      send_idle("5");
      check("t1_acc", acc_a[0], 32'h08);

      // Subtract through zero
      send_idle("r");
      send_idle("5");
      send_idle("-");
      send_idle("9");
      check("t2_acc_wrap", acc_a[0], 32'hFC);
      check("t2_acc_sat", acc_a[1], 32'h00);
      send_idle("+");

      // Overflow on add, then 'r'
      send_idle("r");
      for (int i = 0; i < 18; i++) send_idle("F");
      check("t3_acc_wrap", acc_a[0], 32'h0E);
      check("t3_acc_sat", acc_a[1], 32'hFF);
      send_idle("r");

      // Stalled TX: later requests coalesce into one report of the final value
      tx_ready = 1'b0;
      send_byte("1", 1'b0, 1'b1, 1'b1);
      send_byte("1", 1'b0, 1'b0, 1'b0);
      send_byte("1", 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) push_report(k, 99);
      repeat (32) @(posedge clk);
      #1 tx_ready = 1'b1;
      wait_idle(300);

      // clr beats a coincident byte; lowercase / junk bytes
      send_byte("7", 1'b1, 1'b1, 1'b1);
      send_idle("a");
      send_idle("x");

      // clr while busy drops the pending request but lets the report finish
      tx_ready = 1'b0;
      send_byte("2", 1'b0, 1'b1, 1'b1);
      send_byte("3", 1'b0, 1'b0, 1'b0);
      send_byte("9", 1'b1, 1'b0, 1'b1);
      repeat (5) @(posedge clk);
      #1 tx_ready = 1'b1;
      wait_idle(300);

      // Randomized bytes with random TX back-pressure
      rnd_ready = 1'b1;
      for (int i = 0; i < 120; i++) begin
         int sel = $urandom_range(0, 9);
         int n   = $urandom_range(0, 15);
         case (sel)
            0, 1, 2, 3: b = (n < 10) ? 8'(8'h30 + n) : 8'(8'h37 + n);
            4:          b = 8'(8'h61 + $urandom_range(0, 5));
            5:          b = 8'h2B;
            6:          b = 8'h2D;
            7:          b = ($urandom_range(0, 1) != 0) ? 8'h52 : 8'h72;
            8:          b = 8'($urandom_range(0, 255));
            default:    b = 8'h46;
         endcase
         send_byte(b, ($urandom_range(0, 11) == 0), 1'b1, 1'b1);
         wait_idle(400);
      end
      rnd_ready = 1'b0;
      @(posedge clk); #1 tx_ready = 1'b1;
      wait_idle(300);

      // Asynchronous reset while the second report byte is presented
      tx_ready = 1'b0;
      send_byte("5", 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) push_report(k, 1);
      @(posedge clk); #1 tx_ready = 1'b1;
      @(posedge clk); #1 tx_ready = 1'b0;
      #5 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         model_reset(k);
         check($sformatf("t6_tx_valid[%0d]", k), {31'd0, txv[k]}, 32'd0);
         check($sformatf("t6_busy[%0d]", k), {31'd0, busy_o[k]}, 32'd0);
         check($sformatf("t6_acc[%0d]", k), acc_a[k], 32'd0);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tx_ready = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check_regs();

      // Final report
      for (int k = 0; k < 3; k++) check($sformatf("tx_missing[%0d]", k), 32'(exp_size(k)), 32'd0);
      check("tx_extra", 32'(extra), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
